// File: rtl/spi_mon_pkg.sv
// rtl/spi_mon_pkg.sv - shared types and constants for the SPI slave monitor core
package spi_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        BLOCK = 2'd2
    } spi_mon_state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_PARTIAL  = 2'b01;
    localparam logic [1:0] ERR_MULTI_CS = 2'b10;

    function automatic int cs_width(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage

// File: rtl/spi_slave_monitor_core_if.sv
// rtl/spi_slave_monitor_core_if.sv - decoded-record valid/ready channel towards the monitor proxy
interface spi_slave_monitor_core_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CSW        = 1
);
    logic                  rec_valid;
    logic                  rec_ready;
    logic [DATA_WIDTH-1:0] rec_mosi;
    logic [DATA_WIDTH-1:0] rec_miso;
    logic [CSW-1:0]        rec_cs_idx;

    modport master (
        output rec_valid,
        output rec_mosi,
        output rec_miso,
        output rec_cs_idx,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_mosi,
        input  rec_miso,
        input  rec_cs_idx,
        output rec_ready
    );
endinterface

// File: rtl/spi_mon_fifo.sv
// rtl/spi_mon_fifo.sv - synchronous record FIFO, no bypass, accepts a push while full if popping
module spi_mon_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Zero when empty so the record outputs read 0 out of reset
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/spi_slave_monitor_core.sv
// rtl/spi_slave_monitor_core.sv - SPI slave-side monitor: pin sync, edge detect, frame FSM, record FIFO
// Define SPI_MON_FRAME_ERR_EN to add the err_pulse/err_code frame-error outputs.
module spi_slave_monitor_core
    import spi_mon_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_CS      = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    localparam int CSW        = cs_width(NUM_CS),
    localparam int FCW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              pclk,
    input  logic              areset,
    input  logic              sclk,
    input  logic [NUM_CS-1:0] cs_n,
    input  logic              mosi,
    input  logic              miso,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic              cfg_lsb_first,
    spi_slave_monitor_core_if.master rec,
    output logic [FCW-1:0]    fifo_count,
    output logic              ovf_sticky,
    input  logic              ovf_clr
`ifdef SPI_MON_FRAME_ERR_EN
    ,
    output logic              err_pulse,
    output logic [1:0]        err_code
`endif
);
    localparam int CNTW = $clog2(DATA_WIDTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] mosi;
        logic [DATA_WIDTH-1:0] miso;
        logic [CSW-1:0]        cs_idx;
    } rec_t;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, miso_sync;
    logic [NUM_CS-1:0]      cs_sync [SYNC_STAGES];
    logic                   sclk_prev;
    logic                   sclk_s, mosi_s, miso_s;
    logic [NUM_CS-1:0]      cs_low;
    logic                   cs_any, cs_multi;
    logic [CSW-1:0]         cs_idx;

    spi_mon_state_e         state, state_nxt;
    logic                   start, shift_en, frame_done, sample_edge;
    logic                   cpol_q, cpha_q, lsb_q;
    logic [CSW-1:0]         cs_idx_q;
    logic [CNTW-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]  mosi_sr, miso_sr;
    logic                   push_q;

    rec_t                   wr_rec, rd_rec;
    logic                   fifo_full, fifo_empty, pop, ovf_set;

    // Synchronisers reset to the idle pin levels so no spurious edge or select follows reset
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            sclk_sync <= {SYNC_STAGES{cfg_cpol}};
            mosi_sync <= '0;
            miso_sync <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) cs_sync[s] <= '1;
            sclk_prev <= cfg_cpol;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            miso_sync <= {miso_sync[SYNC_STAGES-2:0], miso};
            cs_sync[0] <= cs_n;
            for (int s = 1; s < SYNC_STAGES; s++) cs_sync[s] <= cs_sync[s-1];
            sclk_prev <= sclk_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign miso_s = miso_sync[SYNC_STAGES-1];

    always_comb begin
        cs_low   = ~cs_sync[SYNC_STAGES-1];
        cs_any   = |cs_low;
        cs_multi = (cs_low & (cs_low - NUM_CS'(1))) != '0;
        cs_idx   = '0;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_low[i]) cs_idx = CSW'(i);
        end
    end

    // Leading edge leaves the idle level; CPHA picks leading (0) or trailing (1) as the sample edge
    assign sample_edge = (sclk_s ^ sclk_prev) && ((sclk_s != cpol_q) ^ cpha_q);

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cs_multi)    state_nxt = BLOCK;
                else if (cs_any) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (!cs_any)       state_nxt = IDLE;
                else if (cs_multi) state_nxt = BLOCK;
            end
            BLOCK: begin
                if (!cs_any) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SPI_MON_FRAME_ERR_EN
    logic err_partial, err_multi;
`endif

    always_comb begin
        start      = (state == IDLE) && (state_nxt == SHIFT);
        shift_en   = (state == SHIFT) && (state_nxt == SHIFT) && sample_edge;
        frame_done = shift_en && (bit_cnt == CNTW'(DATA_WIDTH - 1));
`ifdef SPI_MON_FRAME_ERR_EN
        err_partial = (state == SHIFT) && (state_nxt == IDLE) && (bit_cnt != '0);
        err_multi   = (state != BLOCK) && (state_nxt == BLOCK);
`endif
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            cs_idx_q <= '0;
            bit_cnt  <= '0;
            mosi_sr  <= '0;
            miso_sr  <= '0;
            push_q   <= 1'b0;
        end else begin
            // Registered push: the shifters are stable for at least one more cycle at legal sclk rates
            push_q <= frame_done;
            if (start) begin
                cpol_q   <= cfg_cpol;
                cpha_q   <= cfg_cpha;
                lsb_q    <= cfg_lsb_first;
                cs_idx_q <= cs_idx;
                bit_cnt  <= '0;
            end else if (shift_en) begin
                bit_cnt <= frame_done ? '0 : bit_cnt + CNTW'(1);
                if (lsb_q) begin
                    mosi_sr <= {mosi_s, mosi_sr[DATA_WIDTH-1:1]};
                    miso_sr <= {miso_s, miso_sr[DATA_WIDTH-1:1]};
                end else begin
                    mosi_sr <= {mosi_sr[DATA_WIDTH-2:0], mosi_s};
                    miso_sr <= {miso_sr[DATA_WIDTH-2:0], miso_s};
                end
            end
        end
    end

    assign wr_rec = '{mosi: mosi_sr, miso: miso_sr, cs_idx: cs_idx_q};
    assign pop    = !fifo_empty && rec.rec_ready;

    spi_mon_fifo #(
        .WIDTH ($bits(rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (pclk),
        .rst_n (areset),
        .push  (push_q),
        .wdata (wr_rec),
        .pop   (pop),
        .rdata (rd_rec),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rec.rec_valid  = !fifo_empty;
    assign rec.rec_mosi   = rd_rec.mosi;
    assign rec.rec_miso   = rd_rec.miso;
    assign rec.rec_cs_idx = rd_rec.cs_idx;

    assign ovf_set = push_q && fifo_full && !pop;

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset)      ovf_sticky <= 1'b0;
        else if (ovf_set) ovf_sticky <= 1'b1;
        else if (ovf_clr) ovf_sticky <= 1'b0;
    end

`ifdef SPI_MON_FRAME_ERR_EN
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            err_pulse <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            err_pulse <= err_partial || err_multi;
            if (err_multi)        err_code <= ERR_MULTI_CS;
            else if (err_partial) err_code <= ERR_PARTIAL;
        end
    end
`endif
endmodule

// File: tb/tb_spi_slave_monitor_core.sv
// tb/tb_spi_slave_monitor_core.sv - directed self-checking bench for spi_slave_monitor_core
module tb_spi_slave_monitor_core;
    import spi_mon_pkg::*;

    localparam int DW    = 8;
    localparam int NCS   = 4;
    localparam int FD    = 4;
    localparam int SS    = 2;
    localparam int CLK_P = 10;
    localparam int H     = 4;

    logic           pclk = 1'b0;
    logic           areset = 1'b0;
    logic           sclk = 1'b0;
    logic [NCS-1:0] cs_n = '1;
    logic           mosi = 1'b0;
    logic           miso = 1'b0;
    logic           cfg_cpol = 1'b0;
    logic           cfg_cpha = 1'b0;
    logic           cfg_lsb_first = 1'b0;
    logic           ovf_clr = 1'b0;
    logic [2:0]     fifo_count;
    logic           ovf_sticky;
`ifdef SPI_MON_FRAME_ERR_EN
    logic           err_pulse;
    logic [1:0]     err_code;
`endif

    int   tests = 0;
    int   fails = 0;
    time  t_sample = 0;
    time  t_valid = 0;
    logic rv_prev = 1'b0;

    spi_slave_monitor_core_if #(.DATA_WIDTH(DW), .CSW(2)) rec_bus ();

    spi_slave_monitor_core #(
        .DATA_WIDTH (DW),
        .NUM_CS     (NCS),
        .FIFO_DEPTH (FD),
        .SYNC_STAGES(SS)
    ) dut (
        .pclk         (pclk),
        .areset       (areset),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso),
        .cfg_cpol     (cfg_cpol),
        .cfg_cpha     (cfg_cpha),
        .cfg_lsb_first(cfg_lsb_first),
        .rec          (rec_bus),
        .fifo_count   (fifo_count),
        .ovf_sticky   (ovf_sticky),
        .ovf_clr      (ovf_clr)
`ifdef SPI_MON_FRAME_ERR_EN
        ,
        .err_pulse    (err_pulse),
        .err_code     (err_code)
`endif
    );

    always #(CLK_P/2) pclk = ~pclk;

    always @(negedge pclk) begin
        if (rec_bus.rec_valid && !rv_prev && t_valid == 0) t_valid = $time;
        rv_prev = rec_bus.rec_valid;
    end

    task automatic step(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic spi_bits(input logic [7:0] mo, input logic [7:0] mi, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            int b;
            b = cfg_lsb_first ? i : 7 - i;
            if (!cfg_cpha) begin
                mosi = mo[b]; miso = mi[b];
                step(H);
                sclk = ~cfg_cpol; t_sample = $time;
                step(H);
                sclk = cfg_cpol;
            end else begin
                sclk = ~cfg_cpol;
                mosi = mo[b]; miso = mi[b];
                step(H);
                sclk = cfg_cpol; t_sample = $time;
                step(H);
            end
        end
    endtask

    task automatic set_mode(input logic cpol, input logic cpha, input logic lsb);
        cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb_first = lsb;
        sclk = cpol;
        step(6);
    endtask

    task automatic cs_select(input logic [NCS-1:0] v);
        cs_n = v;
        step(6);
    endtask

    task automatic cs_release();
        step(H);
        cs_n = '1;
        step(8);
    endtask

    task automatic pop_rec(output bit ok, output logic [7:0] mo, output logic [7:0] mi,
                           output logic [1:0] idx);
        ok = 1'b0; mo = '0; mi = '0; idx = '0;
        step(1);
        for (int i = 0; i < 50 && !ok; i++) begin
            if (rec_bus.rec_valid === 1'b1) ok = 1'b1;
            else step(1);
        end
        if (ok) begin
            mo = rec_bus.rec_mosi; mi = rec_bus.rec_miso; idx = rec_bus.rec_cs_idx;
            rec_bus.rec_ready = 1'b1;
            step(1);
            rec_bus.rec_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        areset = 1'b0;
        step(3);
        tests++; if (rec_bus.rec_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0b exp=0", rec_bus.rec_valid); end
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        tests++; if (ovf_sticky !== 1'b0) begin fails++; $display("FAIL reset_ovf got=%0b exp=0", ovf_sticky); end
        tests++; if (rec_bus.rec_mosi !== 8'h00) begin fails++; $display("FAIL reset_mosi got=%0h exp=0", rec_bus.rec_mosi); end
`ifdef SPI_MON_FRAME_ERR_EN
        tests++; if (err_code !== 2'b00) begin fails++; $display("FAIL reset_err_code got=%0b exp=0", err_code); end
`endif
        areset = 1'b1;
        step(3);
    endtask

    task automatic test_mode0();
        bit ok; logic [7:0] mo, mi; logic [1:0] idx;
        time lat;
        set_mode(1'b0, 1'b0, 1'b0);
        cs_select(4'b1110);
        t_valid = 0;
        spi_bits(8'hA5, 8'h3C, 8);
        step(8);
        lat = t_valid - t_sample;
        tests++; if (lat !== time'((SS + 2) * CLK_P + CLK_P/2 - 1)) begin fails++; $display("FAIL mode0_latency got=%0d exp=%0d", lat, (SS + 2) * CLK_P + CLK_P/2 - 1); end
        cs_release();
        pop_rec(ok, mo, mi, idx);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL mode0_valid got=%0b exp=1", ok); end
        tests++; if (mo !== 8'hA5) begin fails++; $display("FAIL mode0_mosi got=%0h exp=a5", mo); end
        tests++; if (mi !== 8'h3C) begin fails++; $display("FAIL mode0_miso got=%0h exp=3c", mi); end
        tests++; if (idx !== 2'd0) begin fails++; $display("FAIL mode0_cs_idx got=%0d exp=0", idx); end
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL mode0_count_after got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_modes();
        bit ok; logic [7:0] mo, mi; logic [1:0] idx;
        logic [2:0] cfg [4];
        cfg[0] = 3'b010; cfg[1] = 3'b100; cfg[2] = 3'b110; cfg[3] = 3'b001;
        for (int m = 0; m < 4; m++) begin
            set_mode(cfg[m][2], cfg[m][1], cfg[m][0]);
            cs_select(4'b1110);
            spi_bits(8'h81, 8'h12, 8);
            spi_bits(8'h7E, 8'hC4, 8);
            cs_release();
            pop_rec(ok, mo, mi, idx);
            tests++; if (ok !== 1'b1 || mo !== 8'h81) begin fails++; $display("FAIL modes_cfg%0b_rec0_mosi got=%0h exp=81", cfg[m], mo); end
            tests++; if (mi !== 8'h12) begin fails++; $display("FAIL modes_cfg%0b_rec0_miso got=%0h exp=12", cfg[m], mi); end
            pop_rec(ok, mo, mi, idx);
            tests++; if (ok !== 1'b1 || mo !== 8'h7E) begin fails++; $display("FAIL modes_cfg%0b_rec1_mosi got=%0h exp=7e", cfg[m], mo); end
            tests++; if (mi !== 8'hC4) begin fails++; $display("FAIL modes_cfg%0b_rec1_miso got=%0h exp=c4", cfg[m], mi); end
        end
    endtask

    task automatic test_overflow();
        bit ok; logic [7:0] mo, mi; logic [1:0] idx;
        set_mode(1'b0, 1'b0, 1'b0);
        cs_select(4'b1110);
        for (int i = 0; i < 6; i++) spi_bits(8'(8'h10 + i), 8'(8'hF0 - i), 8);
        cs_release();
        tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL ovf_count got=%0d exp=4", fifo_count); end
        tests++; if (ovf_sticky !== 1'b1) begin fails++; $display("FAIL ovf_sticky_set got=%0b exp=1", ovf_sticky); end
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        tests++; if (ovf_sticky !== 1'b0) begin fails++; $display("FAIL ovf_sticky_clr got=%0b exp=0", ovf_sticky); end
        for (int i = 0; i < 4; i++) begin
            pop_rec(ok, mo, mi, idx);
            tests++; if (ok !== 1'b1 || mo !== 8'(8'h10 + i) || mi !== 8'(8'hF0 - i)) begin
                fails++; $display("FAIL ovf_rec%0d got=%0h/%0h exp=%0h/%0h", i, mo, mi, 8'(8'h10 + i), 8'(8'hF0 - i));
            end
        end
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL ovf_drained got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_multi_cs();
        bit ok; logic [7:0] mo, mi; logic [1:0] idx;
        set_mode(1'b0, 1'b0, 1'b0);
        cs_select(4'b1011);
        spi_bits(8'h5A, 8'hC3, 8);
        cs_release();
        pop_rec(ok, mo, mi, idx);
        tests++; if (ok !== 1'b1 || idx !== 2'd2) begin fails++; $display("FAIL cs2_idx got=%0d exp=2", idx); end
        tests++; if (mo !== 8'h5A || mi !== 8'hC3) begin fails++; $display("FAIL cs2_data got=%0h/%0h exp=5a/c3", mo, mi); end
        cs_select(4'b0101);
        tests++; if (dut.state !== BLOCK) begin fails++; $display("FAIL multi_cs_state got=%0d exp=%0d", dut.state, BLOCK); end
        spi_bits(8'hFF, 8'h00, 8);
        cs_release();
        tests++; if (fifo_count !== 3'd0 || rec_bus.rec_valid !== 1'b0) begin fails++; $display("FAIL multi_cs_norec got=%0d exp=0", fifo_count); end
        tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL multi_cs_idle got=%0d exp=%0d", dut.state, IDLE); end
`ifdef SPI_MON_FRAME_ERR_EN
        tests++; if (err_code !== ERR_MULTI_CS) begin fails++; $display("FAIL multi_cs_err got=%0b exp=10", err_code); end
`endif
    endtask

    task automatic test_partial_and_reset();
        bit ok; logic [7:0] mo, mi; logic [1:0] idx;
        set_mode(1'b0, 1'b0, 1'b0);
        cs_select(4'b1110);
        spi_bits(8'hB7, 8'h4D, 5);
        cs_release();
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL partial_norec got=%0d exp=0", fifo_count); end
`ifdef SPI_MON_FRAME_ERR_EN
        tests++; if (err_code !== ERR_PARTIAL) begin fails++; $display("FAIL partial_err got=%0b exp=01", err_code); end
`endif
        cs_select(4'b1110);
        spi_bits(8'h11, 8'h22, 8);
        spi_bits(8'h33, 8'h44, 3);
        tests++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL prereset_count got=%0d exp=1", fifo_count); end
        areset = 1'b0;
        step(2);
        tests++; if (rec_bus.rec_valid !== 1'b0 || fifo_count !== 3'd0) begin fails++; $display("FAIL midreset_fifo got=%0b/%0d exp=0/0", rec_bus.rec_valid, fifo_count); end
        tests++; if (rec_bus.rec_mosi !== 8'h00 || ovf_sticky !== 1'b0) begin fails++; $display("FAIL midreset_outs got=%0h/%0b exp=0/0", rec_bus.rec_mosi, ovf_sticky); end
`ifdef SPI_MON_FRAME_ERR_EN
        tests++; if (err_code !== 2'b00) begin fails++; $display("FAIL midreset_err got=%0b exp=0", err_code); end
`endif
        cs_n = '1; sclk = 1'b0;
        step(2);
        areset = 1'b1;
        step(4);
        cs_select(4'b1110);
        spi_bits(8'hC9, 8'h36, 8);
        cs_release();
        pop_rec(ok, mo, mi, idx);
        tests++; if (ok !== 1'b1 || mo !== 8'hC9 || mi !== 8'h36) begin fails++; $display("FAIL postreset_rec got=%0h/%0h exp=c9/36", mo, mi); end
    endtask

    initial begin
        rec_bus.rec_ready = 1'b0;
        test_reset();
        test_mode0();
        test_modes();
        test_overflow();
        test_multi_cs();
        test_partial_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
